// File: rtl/mmio_router_pkg.sv
// Shared types for the MMIO router: FSM states, target select and bus widths.
package MMIORouterStruct;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int MASK_W = 8;

  localparam logic [63:0] TIMER_BASE_DEFAULT = 64'h0000_0000_0200_0000;
  localparam logic [63:0] TIMER_SIZE_DEFAULT = 64'h0000_0000_0001_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    RESP    = 2'd3
  } router_state_e;

  typedef enum logic {
    TGT_RAM   = 1'b0,
    TGT_TIMER = 1'b1
  } target_e;

endpackage

// File: rtl/mem_ift.sv
// Simple memory bus: independent read and write channels, each closed by a valid.
interface Mem_ift;

  logic                                ren;
  logic [MMIORouterStruct::ADDR_W-1:0] raddr;
  logic [MMIORouterStruct::DATA_W-1:0] rdata;
  logic                                rvalid;
  logic                                wen;
  logic [MMIORouterStruct::ADDR_W-1:0] waddr;
  logic [MMIORouterStruct::DATA_W-1:0] wdata;
  logic [MMIORouterStruct::MASK_W-1:0] wmask;
  logic                                wvalid;

  modport Master (output ren, raddr, wen, waddr, wdata, wmask,
                  input  rdata, rvalid, wvalid);
  modport Slave  (input  ren, raddr, wen, waddr, wdata, wmask,
                  output rdata, rvalid, wvalid);

endinterface

// File: rtl/mmio_router_decode.sv
// Address decode: flags addresses inside the timer window [base, base+size).
module mmio_decode
  import MMIORouterStruct::*;
#(
  parameter logic [63:0] TIMER_BASE = TIMER_BASE_DEFAULT,
  parameter logic [63:0] TIMER_SIZE = TIMER_SIZE_DEFAULT
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              is_timer
);

  logic [64:0] limit_s;

  // Compare in 65 bits so a window touching the top of the map cannot wrap.
  always_comb begin
    limit_s  = {1'b0, TIMER_BASE} + {1'b0, TIMER_SIZE};
    is_timer = ({1'b0, addr} >= {1'b0, TIMER_BASE}) && ({1'b0, addr} < limit_s);
  end

endmodule

// File: rtl/mmio_router.sv
// Routes one core transaction at a time to RAM or timer, with a wait-cycle timeout.
module mmio_router
  import MMIORouterStruct::*;
#(
  parameter logic [63:0] TIMER_BASE = TIMER_BASE_DEFAULT,
  parameter logic [63:0] TIMER_SIZE = TIMER_SIZE_DEFAULT,
  parameter logic [7:0]  TIMEOUT    = 8'd255
) (
  input  logic   clk,
  input  logic   rstn,
  Mem_ift.Slave  core_ift,
  Mem_ift.Master ram_ift,
  Mem_ift.Master timer_ift,
  output logic   bus_err,
  output logic   busy
);

  router_state_e     state_r;
  target_e           tgt_r;
  logic [7:0]        cnt_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic [MASK_W-1:0] wmask_r;
  logic              ram_ren_r;
  logic              ram_wen_r;
  logic              timer_ren_r;
  logic              timer_wen_r;
  logic              core_rvalid_r;
  logic              core_wvalid_r;
  logic              bus_err_r;
  logic              busy_r;

  logic [ADDR_W-1:0] req_addr_s;
  logic              is_timer_s;
  logic              tgt_rvalid_s;
  logic              tgt_wvalid_s;
  logic [DATA_W-1:0] tgt_rdata_s;

  // Decode the address IDLE is about to latch; a pending read outranks a write.
  always_comb begin
    if (core_ift.ren) begin
      req_addr_s = core_ift.raddr;
    end else begin
      req_addr_s = core_ift.waddr;
    end
  end

  mmio_decode #(
    .TIMER_BASE (TIMER_BASE),
    .TIMER_SIZE (TIMER_SIZE)
  ) u_decode (
    .addr     (req_addr_s),
    .is_timer (is_timer_s)
  );

  // Completion signals come only from the target latched for this transaction.
  always_comb begin
    if (tgt_r == TGT_TIMER) begin
      tgt_rvalid_s = timer_ift.rvalid;
      tgt_wvalid_s = timer_ift.wvalid;
      tgt_rdata_s  = timer_ift.rdata;
    end else begin
      tgt_rvalid_s = ram_ift.rvalid;
      tgt_wvalid_s = ram_ift.wvalid;
      tgt_rdata_s  = ram_ift.rdata;
    end
  end

  // Transaction FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r       <= IDLE;
      tgt_r         <= TGT_RAM;
      cnt_r         <= 8'd0;
      addr_r        <= {ADDR_W{1'b0}};
      wdata_r       <= {DATA_W{1'b0}};
      wmask_r       <= {MASK_W{1'b0}};
      rdata_r       <= {DATA_W{1'b0}};
      ram_ren_r     <= 1'b0;
      ram_wen_r     <= 1'b0;
      timer_ren_r   <= 1'b0;
      timer_wen_r   <= 1'b0;
      core_rvalid_r <= 1'b0;
      core_wvalid_r <= 1'b0;
      bus_err_r     <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      bus_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (core_ift.ren) begin
            addr_r      <= core_ift.raddr;
            tgt_r       <= is_timer_s ? TGT_TIMER : TGT_RAM;
            ram_ren_r   <= ~is_timer_s;
            timer_ren_r <= is_timer_s;
            cnt_r       <= 8'd0;
            busy_r      <= 1'b1;
            state_r     <= RD_WAIT;
          end else if (core_ift.wen) begin
            addr_r      <= core_ift.waddr;
            wdata_r     <= core_ift.wdata;
            wmask_r     <= core_ift.wmask;
            tgt_r       <= is_timer_s ? TGT_TIMER : TGT_RAM;
            ram_wen_r   <= ~is_timer_s;
            timer_wen_r <= is_timer_s;
            cnt_r       <= 8'd0;
            busy_r      <= 1'b1;
            state_r     <= WR_WAIT;
          end
        end
        RD_WAIT: begin
          // A valid on the last allowed cycle still completes normally.
          if (tgt_rvalid_s) begin
            rdata_r       <= tgt_rdata_s;
            core_rvalid_r <= 1'b1;
            ram_ren_r     <= 1'b0;
            timer_ren_r   <= 1'b0;
            state_r       <= RESP;
          end else if (cnt_r == TIMEOUT) begin
            rdata_r       <= {DATA_W{1'b0}};
            core_rvalid_r <= 1'b1;
            bus_err_r     <= 1'b1;
            ram_ren_r     <= 1'b0;
            timer_ren_r   <= 1'b0;
            state_r       <= RESP;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        WR_WAIT: begin
          if (tgt_wvalid_s) begin
            core_wvalid_r <= 1'b1;
            ram_wen_r     <= 1'b0;
            timer_wen_r   <= 1'b0;
            state_r       <= RESP;
          end else if (cnt_r == TIMEOUT) begin
            core_wvalid_r <= 1'b1;
            bus_err_r     <= 1'b1;
            ram_wen_r     <= 1'b0;
            timer_wen_r   <= 1'b0;
            state_r       <= RESP;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        RESP: begin
          core_rvalid_r <= 1'b0;
          core_wvalid_r <= 1'b0;
          rdata_r       <= {DATA_W{1'b0}};
          busy_r        <= 1'b0;
          state_r       <= IDLE;
        end
        default: begin
          ram_ren_r     <= 1'b0;
          ram_wen_r     <= 1'b0;
          timer_ren_r   <= 1'b0;
          timer_wen_r   <= 1'b0;
          core_rvalid_r <= 1'b0;
          core_wvalid_r <= 1'b0;
          rdata_r       <= {DATA_W{1'b0}};
          busy_r        <= 1'b0;
          state_r       <= IDLE;
        end
      endcase
    end
  end

  assign core_ift.rvalid  = core_rvalid_r;
  assign core_ift.wvalid  = core_wvalid_r;
  assign core_ift.rdata   = rdata_r;

  assign ram_ift.ren      = ram_ren_r;
  assign ram_ift.raddr    = addr_r;
  assign ram_ift.wen      = ram_wen_r;
  assign ram_ift.waddr    = addr_r;
  assign ram_ift.wdata    = wdata_r;
  assign ram_ift.wmask    = wmask_r;

  assign timer_ift.ren    = timer_ren_r;
  assign timer_ift.raddr  = addr_r;
  assign timer_ift.wen    = timer_wen_r;
  assign timer_ift.waddr  = addr_r;
  assign timer_ift.wdata  = wdata_r;
  assign timer_ift.wmask  = wmask_r;

  assign bus_err = bus_err_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_mmio_router.sv
// Bench for mmio_router: transaction-level model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_mmio_router;
  import MMIORouterStruct::*;

  localparam logic [63:0] TB_BASE = 64'h0000_0000_0200_0000;
  localparam logic [63:0] TB_SIZE = 64'h0000_0000_0001_0000;
  localparam int          TMO     = 255;

  logic clk = 1'b0;
  logic rstn;
  logic bus_err;
  logic busy;
  always #5 clk = ~clk;

  Mem_ift core_if ();
  Mem_ift ram_if ();
  Mem_ift timer_if ();

  mmio_router #(
    .TIMER_BASE (TB_BASE),
    .TIMER_SIZE (TB_SIZE),
    .TIMEOUT    (8'd255)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .core_ift  (core_if),
    .ram_ift   (ram_if),
    .timer_ift (timer_if),
    .bus_err   (bus_err),
    .busy      (busy)
  );

  // Target models: timer answers in the same cycle, RAM after ram_delay strobe cycles.
  logic [63:0] mtime;
  int          ram_delay;
  bit          ram_never;
  int          ram_cnt = 0;

  function automatic logic [63:0] ram_word(input logic [63:0] a);
    return a ^ 64'hC0FF_EE00_0000_1234;
  endfunction

  assign timer_if.rvalid = timer_if.ren;
  assign timer_if.wvalid = timer_if.wen;
  assign timer_if.rdata  = mtime;

  always @(posedge clk) begin
    if (ram_if.ren || ram_if.wen) ram_cnt <= ram_cnt + 1;
    else ram_cnt <= 0;
  end
  assign ram_if.rvalid = ram_if.ren && !ram_never && (ram_cnt == ram_delay - 1);
  assign ram_if.wvalid = ram_if.wen && !ram_never && (ram_cnt == ram_delay - 1);
  assign ram_if.rdata  = ram_word(ram_if.raddr);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Transaction model: one outstanding transaction with start cycle and total length.
  int          cyc     = 0;
  bit          m_act   = 1'b0;
  int          m_start = 0;
  int          m_len   = 0;
  bit          m_rd, m_tim, m_err;
  logic [63:0] m_addr, m_wdata, m_rdata;
  logic [7:0]  m_mask;

  initial begin : model
    forever begin
      @(posedge clk);
      if (!rstn) begin
        m_act = 1'b0;
      end else if (!(m_act && cyc <= m_start + m_len) && (core_if.ren || core_if.wen)) begin
        m_act   = 1'b1;
        m_start = cyc;
        m_rd    = core_if.ren;
        m_addr  = m_rd ? core_if.raddr : core_if.waddr;
        m_wdata = core_if.wdata;
        m_mask  = core_if.wmask;
        m_tim   = (m_addr >= TB_BASE) && ((m_addr - TB_BASE) < TB_SIZE);
        m_err   = 1'b0;
        m_rdata = 64'h0;
        if (m_tim) begin
          m_len = 2;
          if (m_rd) m_rdata = mtime;
        end else if (ram_never || (ram_delay - 1) > TMO) begin
          m_len = TMO + 2;
          m_err = 1'b1;
        end else begin
          m_len = ram_delay + 1;
          if (m_rd) m_rdata = ram_word(m_addr);
        end
      end
      cyc = cyc + 1;
    end
  end

  bit chk_en = 1'b0;

  initial begin : compare
    logic [7:0]  e_v;
    logic [7:0]  g_v;
    logic [63:0] e_rd;
    int          t;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        t    = cyc;
        e_v  = 8'h00;
        e_rd = 64'h0;
        if (m_act && t > m_start && t <= m_start + m_len) begin
          e_v[7] = 1'b1;
          if (t == m_start + m_len) begin
            e_v[2] = m_rd;
            e_v[1] = !m_rd;
            e_v[0] = m_err;
            e_rd   = m_rdata;
          end else if (m_tim) begin
            e_v[4] = m_rd;
            e_v[3] = !m_rd;
          end else begin
            e_v[6] = m_rd;
            e_v[5] = !m_rd;
          end
        end
        g_v = {busy, ram_if.ren, ram_if.wen, timer_if.ren, timer_if.wen,
               core_if.rvalid, core_if.wvalid, bus_err};
        check("cycle_ctl", {56'h0, g_v}, {56'h0, e_v});
        check("cycle_rdata", core_if.rdata, e_rd);
        if (e_v[6]) check("ram_raddr", ram_if.raddr, m_addr);
        if (e_v[4]) check("timer_raddr", timer_if.raddr, m_addr);
        if (e_v[5]) begin
          check("ram_waddr", ram_if.waddr, m_addr);
          check("ram_wdata", ram_if.wdata, m_wdata);
          check("ram_wmask", {56'h0, ram_if.wmask}, {56'h0, m_mask});
        end
        if (e_v[3]) begin
          check("timer_waddr", timer_if.waddr, m_addr);
          check("timer_wdata", timer_if.wdata, m_wdata);
          check("timer_wmask", {56'h0, timer_if.wmask}, {56'h0, m_mask});
        end
      end
    end
  end

  task automatic do_read(input logic [63:0] a, output int lat, output logic [63:0] d,
                         output int ec, output int rs, output int ts);
    bit done;
    done = 1'b0;
    @(negedge clk);
    core_if.ren   = 1'b1;
    core_if.raddr = a;
    lat = 0; ec = 0; rs = 0; ts = 0; d = 64'h0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (bus_err) ec++;
      if (ram_if.ren) rs++;
      if (timer_if.ren) ts++;
      if (core_if.rvalid) begin
        d    = core_if.rdata;
        done = 1'b1;
      end
    end
    core_if.ren = 1'b0;
    check("rd_completed", {63'h0, done}, 64'h1);
  endtask

  task automatic do_write(input logic [63:0] a, input logic [63:0] wd, input logic [7:0] m,
                          input bit mutate, output int lat, output int ec, output int rs, output int ts);
    bit done;
    done = 1'b0;
    @(negedge clk);
    core_if.wen   = 1'b1;
    core_if.waddr = a;
    core_if.wdata = wd;
    core_if.wmask = m;
    lat = 0; ec = 0; rs = 0; ts = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (bus_err) ec++;
      if (ram_if.wen) rs++;
      if (timer_if.wen) ts++;
      if (core_if.wvalid) begin
        done = 1'b1;
      end else if (mutate) begin
        core_if.waddr = ~a;
        core_if.wdata = ~wd;
        core_if.wmask = ~m;
      end
    end
    core_if.wen = 1'b0;
    check("wr_completed", {63'h0, done}, 64'h1);
  endtask

  initial begin : watchdog
    #200us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          lat, ec, rs, ts, rd_at, wr_at, rv;
    logic [63:0] d, both_d;

    core_if.ren = 1'b0; core_if.wen = 1'b0;
    core_if.raddr = 64'h0; core_if.waddr = 64'h0;
    core_if.wdata = 64'h0; core_if.wmask = 8'h0;
    mtime = 64'h10; ram_delay = 1; ram_never = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_ctl", {56'h0, busy, ram_if.ren, ram_if.wen, timer_if.ren, timer_if.wen,
                        core_if.rvalid, core_if.wvalid, bus_err}, 64'h0);
    check("reset_rdata", core_if.rdata, 64'h0);
    rstn = 1'b1;
    @(negedge clk);

    // Timer read, two-cycle latency.
    do_read(64'h0200_BFF8, lat, d, ec, rs, ts);
    check("tim_rd_lat", lat, 64'd2);
    check("tim_rd_data", d, 64'h10);
    check("tim_rd_err", ec, 64'd0);
    check("tim_rd_tstb", ts, 64'd1);
    check("tim_rd_rstb", rs, 64'd0);

    // RAM write answered on the third strobe cycle.
    ram_delay = 3;
    do_write(64'h8000_0000, 64'hDEAD_BEEF, 8'h0F, 1'b0, lat, ec, rs, ts);
    check("ram_wr_lat", lat, 64'd4);
    check("ram_wr_wen_cycles", rs, 64'd3);
    check("ram_wr_timer_wen", ts, 64'd0);
    check("ram_wr_err", ec, 64'd0);

    // Read and write together: read (RAM, delay 2) first, then the held write (timer).
    ram_delay = 2;
    @(negedge clk);
    core_if.ren = 1'b1; core_if.raddr = 64'h8000_0100;
    core_if.wen = 1'b1; core_if.waddr = 64'h0200_0010;
    core_if.wdata = 64'h1234; core_if.wmask = 8'hFF;
    rd_at = 0; wr_at = 0; both_d = 64'h0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (core_if.rvalid && rd_at == 0) begin
        rd_at = i; both_d = core_if.rdata; core_if.ren = 1'b0;
      end
      if (core_if.wvalid && wr_at == 0) begin
        wr_at = i; core_if.wen = 1'b0;
      end
    end
    core_if.ren = 1'b0; core_if.wen = 1'b0;
    check("both_rd_at", rd_at, 64'd3);
    check("both_rd_data", both_d, 64'hC0FF_EE00_8000_1334);
    check("both_wr_at", wr_at, 64'd6);

    // RAM silent: timeout completion.
    ram_never = 1'b1;
    do_read(64'h8000_0200, lat, d, ec, rs, ts);
    check("tmo_lat", lat, 64'd257);
    check("tmo_data", d, 64'h0);
    check("tmo_err", ec, 64'd1);
    check("tmo_ren_cycles", rs, 64'd256);
    ram_never = 1'b0;

    // Valid on the very cycle the counter hits TIMEOUT wins.
    ram_delay = 256;
    do_read(64'h9000_0000, lat, d, ec, rs, ts);
    check("edge_lat", lat, 64'd257);
    check("edge_data", d, 64'hC0FF_EE00_9000_1234);
    check("edge_err", ec, 64'd0);

    // One cycle later is too late.
    ram_delay = 257;
    do_write(64'h9000_0008, 64'h77, 8'h01, 1'b0, lat, ec, rs, ts);
    check("late_lat", lat, 64'd257);
    check("late_err", ec, 64'd1);

    // Decode boundaries.
    ram_delay = 1;
    mtime = 64'h55;
    do_read(64'h0200_FFFF, lat, d, ec, rs, ts);
    check("bnd_top_timer", ts, 64'd1);
    check("bnd_top_data", d, 64'h55);
    do_read(64'h0200_0000, lat, d, ec, rs, ts);
    check("bnd_base_timer", ts, 64'd1);
    do_read(64'h0201_0000, lat, d, ec, rs, ts);
    check("bnd_above_ram", rs, 64'd1);
    check("bnd_above_tim", ts, 64'd0);
    check("bnd_above_lat", lat, 64'd2);
    do_read(64'h01FF_FFFF, lat, d, ec, rs, ts);
    check("bnd_below_ram", rs, 64'd1);
    check("bnd_below_data", d, 64'hC0FF_EE00_01FF_EDCB);

    // Timer write, then a RAM write whose core inputs change while in flight.
    do_write(64'h0200_4000, 64'hCAFE, 8'hA5, 1'b0, lat, ec, rs, ts);
    check("tim_wr_lat", lat, 64'd2);
    check("tim_wr_tstb", ts, 64'd1);
    ram_delay = 4;
    do_write(64'h8000_0040, 64'h0123_4567_89AB_CDEF, 8'h3C, 1'b1, lat, ec, rs, ts);
    check("mut_wr_lat", lat, 64'd5);
    check("mut_wr_wen_cycles", rs, 64'd4);

    // Reset in the middle of a RAM read.
    ram_never = 1'b1;
    @(negedge clk);
    core_if.ren = 1'b1; core_if.raddr = 64'h8000_0300;
    repeat (3) @(negedge clk);
    check("rst_pre_ren", {63'h0, ram_if.ren}, 64'h1);
    rstn = 1'b0;
    core_if.ren = 1'b0;
    @(negedge clk);
    check("rst_ren_dropped", {63'h0, ram_if.ren}, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_rvalid", {63'h0, core_if.rvalid}, 64'h0);
    rstn = 1'b1;
    ram_never = 1'b0;
    ram_delay = 2;
    rv = 0;
    repeat (10) begin
      @(negedge clk);
      if (core_if.rvalid) rv++;
    end
    check("rst_no_rvalid", rv, 64'd0);
    do_read(64'h8000_0300, lat, d, ec, rs, ts);
    check("post_rst_lat", lat, 64'd3);
    check("post_rst_data", d, 64'hC0FF_EE00_8000_1134);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_router.md
MMIO_ROUTER -- requirements
Module: mmio_router

Interface
REQ-001 SHALL have parameter TIMER_BASE, default 64'h0200_0000, base address of the timer window.
REQ-002 SHALL have parameter TIMER_SIZE, default 64'h0001_0000, byte size of the timer window.
REQ-003 SHALL have parameter TIMEOUT, default 8'd255, maximum downstream wait cycles before error completion.
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port rstn  input  1  synchronous active-low reset.
REQ-006 SHALL have port core_ift  Mem_ift.Slave  --  core-side request and response bus.
REQ-007 SHALL have port ram_ift  Mem_ift.Master  --  RAM-side bus, may respond after several cycles.
REQ-008 SHALL have port timer_ift  Mem_ift.Master  --  timer-side bus, responds same cycle.
REQ-009 SHALL have port bus_err  output  1  one-cycle pulse when a completion is due to timeout.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, RD_WAIT, WR_WAIT, RESP.
REQ-012 IDLE: on core ren, SHALL latch raddr and select target, then go to RD_WAIT; else on core wen, SHALL latch waddr/wdata/wmask and target, then go to WR_WAIT.
REQ-013 When ren and wen are both high in IDLE, read SHALL win; the write is served as a later transaction because the core holds it.
REQ-014 Target SHALL be timer when TIMER_BASE <= addr < TIMER_BASE+TIMER_SIZE (64-bit unsigned compare); otherwise RAM.
REQ-015 In RD_WAIT/WR_WAIT, SHALL drive only the selected target's ren/wen with the latched address, data and mask; the non-selected target's strobes SHALL be 0.
REQ-016 In RD_WAIT, target rvalid SHALL capture rdata into a response register and move to RESP; in WR_WAIT, target wvalid SHALL move to RESP.
REQ-017 In RESP, SHALL assert core rvalid (read) or core wvalid (write) for exactly one cycle with the registered rdata, then go to IDLE.
REQ-018 Core rvalid/wvalid SHALL be 0 in every other state; core rdata SHALL be 0 outside RESP.
REQ-019 Timer read/write latency SHALL be 2 cycles: request seen in cycle N, core response in cycle N+2.
REQ-020 A wait-cycle counter SHALL clear on entry to RD_WAIT/WR_WAIT and increment each wait cycle.
REQ-021 When the counter reaches TIMEOUT with no valid, SHALL go to RESP with rdata 0 and pulse bus_err in that RESP cycle.
REQ-022 If valid arrives in the same cycle the counter reaches TIMEOUT, valid SHALL win and bus_err SHALL stay 0.
REQ-023 Downstream strobes SHALL be registered, so changes on core inputs after latching SHALL NOT affect an in-flight transaction.

Reset
REQ-024 While rstn is low at a clock edge, SHALL set state IDLE, counter 0, latched address/data/mask 0, response register 0.
REQ-025 After reset, all outputs SHALL be 0: core rvalid/wvalid/rdata, ram_ift and timer_ift strobes, bus_err, busy.
REQ-026 Reset mid-transaction SHALL drop downstream strobes on the next cycle and SHALL NOT produce a core response.

Structure
REQ-027 The state enum and default TIMER_BASE/TIMER_SIZE constants SHALL live in a shared package MMIORouterStruct alongside the existing struct packages.
REQ-028 Address decode SHALL be one sub-module, mmio_decode (combinational: addr in, is_timer out).

Verification
REQ-029 Timer read: core ren at raddr 0x0200_BFF8 with mtime=0x10 -> timer ren next cycle, core rvalid 2 cycles after request, rdata 0x10, bus_err 0.
REQ-030 RAM write with 3-cycle wvalid delay: waddr 0x8000_0000, wdata 0xDEAD_BEEF, wmask 0x0F -> ram wen held 3 cycles, core wvalid one cycle, timer wen never 1.
REQ-031 Simultaneous ren and wen in IDLE -> read completes first, write completes in the following transaction.
REQ-032 RAM never responds -> core rvalid after TIMEOUT+2 cycles (257 at default), rdata 0, bus_err one-cycle pulse.
REQ-033 Boundary decode: 0x0200_FFFF -> timer; 0x0201_0000 and 0x01FF_FFFF -> RAM.
REQ-034 rstn low during RD_WAIT -> strobes 0 next cycle, no core rvalid, busy 0, next request served normally.
